// File: rtl/rob_commit_if.sv
// Issue/CDB/register-file/memory signal bundle for rob_commit_unit.
// slave = commit unit side, master = surrounding pipeline (or bench) side.
interface rob_commit_if #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5
);
  logic                          flush;
  logic                          alloc_req;
  logic                          alloc_store;
  logic [REG_INDEX-1:0]          alloc_dest;
  logic                          alloc_ready;
  logic [RB_INDEX-1:0]           alloc_index;
  logic [RB_SIZE-1:0]            cdb_valid;
  logic [RB_SIZE*WORD_SIZE-1:0]  cdb_data;
  logic [RB_SIZE*WORD_SIZE-1:0]  cdb_addr;
  logic [RB_SIZE-1:0]            cdb_clear;
  logic                          rf_we;
  logic [REG_INDEX-1:0]          rf_waddr;
  logic [WORD_SIZE-1:0]          rf_wdata;
  logic                          mem_we;
  logic [WORD_SIZE-1:0]          mem_addr;
  logic [WORD_SIZE-1:0]          mem_wdata;
  logic                          mem_ack;
  logic [RB_INDEX:0]             rb_count;
  logic                          commit_state;

  // Handshakes: an allocation happens on a clock edge where alloc_req && alloc_ready;
  // a store is accepted on the edge where mem_we && mem_ack, and mem_we/mem_addr/mem_wdata
  // stay stable until then.
  modport slave (
    input  flush, alloc_req, alloc_store, alloc_dest, cdb_valid, cdb_data, cdb_addr, mem_ack,
    output alloc_ready, alloc_index, cdb_clear, rf_we, rf_waddr, rf_wdata,
           mem_we, mem_addr, mem_wdata, rb_count, commit_state
  );

  modport master (
    output flush, alloc_req, alloc_store, alloc_dest, cdb_valid, cdb_data, cdb_addr, mem_ack,
    input  alloc_ready, alloc_index, cdb_clear, rf_we, rf_waddr, rf_wdata,
           mem_we, mem_addr, mem_wdata, rb_count, commit_state
  );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder-buffer allocation and in-order commit (register file writes, store handshake).
// Optional ROB_COMMIT_STATS_EN adds a saturating retired-instruction counter.
module rob_commit_unit #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5
) (
  input  logic      clk,
  input  logic      reset,
  rob_commit_if.slave bus
`ifdef ROB_COMMIT_STATS_EN
  ,
  output logic [31:0] commit_count
`endif
);

  localparam int CW = RB_INDEX + 1;

  typedef enum logic {RUN = 1'b0, STORE_WAIT = 1'b1} state_t;

  state_t               state, state_n;
  logic [RB_INDEX-1:0]  head, head_n, tail, tail_n;
  logic [CW-1:0]        count, count_n;
  logic [RB_SIZE-1:0]   busy, busy_n, is_store, store_n;
  logic [REG_INDEX-1:0] dest [RB_SIZE];
  logic [REG_INDEX-1:0] dest_n [RB_SIZE];

  logic                 rf_we_r, rf_we_n;
  logic [REG_INDEX-1:0] rf_waddr_r, rf_waddr_n;
  logic [WORD_SIZE-1:0] rf_wdata_r, rf_wdata_n;
  logic                 mem_we_r, mem_we_n;
  logic [WORD_SIZE-1:0] mem_addr_r, mem_addr_n, mem_wdata_r, mem_wdata_n;
  logic [RB_SIZE-1:0]   cdb_clear_r, cdb_clear_n;

  logic                 full, alloc_fire, retire;
  logic [WORD_SIZE-1:0] data_arr [RB_SIZE];
  logic [WORD_SIZE-1:0] addr_arr [RB_SIZE];

  for (genvar g = 0; g < RB_SIZE; g++) begin : g_unpack
    assign data_arr[g] = bus.cdb_data[g*WORD_SIZE +: WORD_SIZE];
    assign addr_arr[g] = bus.cdb_addr[g*WORD_SIZE +: WORD_SIZE];
  end

  assign full       = (count == CW'(RB_SIZE));
  assign alloc_fire = bus.alloc_req && bus.alloc_ready;

  always_comb begin
    state_n     = state;
    head_n      = head;
    tail_n      = tail;
    busy_n      = busy;
    store_n     = is_store;
    dest_n      = dest;
    rf_we_n     = 1'b0;
    rf_waddr_n  = rf_waddr_r;
    rf_wdata_n  = rf_wdata_r;
    mem_we_n    = mem_we_r;
    mem_addr_n  = mem_addr_r;
    mem_wdata_n = mem_wdata_r;
    cdb_clear_n = '0;
    retire      = 1'b0;

    case (state)
      RUN: begin
        // A valid bit on a slot that is not busy is a leftover from the CDB stage.
        if (busy[head] && bus.cdb_valid[head]) begin
          if (is_store[head]) begin
            mem_we_n    = 1'b1;
            mem_addr_n  = addr_arr[head];
            mem_wdata_n = data_arr[head];
            state_n     = STORE_WAIT;
          end else begin
            rf_we_n    = 1'b1;
            rf_waddr_n = dest[head];
            rf_wdata_n = data_arr[head];
            retire     = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        if (bus.mem_ack) begin
          mem_we_n = 1'b0;
          retire   = 1'b1;
          state_n  = RUN;
        end
      end
      default: state_n = RUN;
    endcase

    if (retire) begin
      cdb_clear_n  = RB_SIZE'(1) << head;
      busy_n[head] = 1'b0;
      head_n       = head + RB_INDEX'(1);
    end

    if (alloc_fire) begin
      busy_n[tail]  = 1'b1;
      store_n[tail] = bus.alloc_store;
      dest_n[tail]  = bus.alloc_dest;
      tail_n        = tail + RB_INDEX'(1);
    end

    count_n = count + CW'(alloc_fire) - CW'(retire);

    // Flush squashes everything, including a store still waiting for its ack.
    if (bus.flush) begin
      state_n     = RUN;
      head_n      = '0;
      tail_n      = '0;
      count_n     = '0;
      busy_n      = '0;
      store_n     = '0;
      rf_we_n     = 1'b0;
      mem_we_n    = 1'b0;
      cdb_clear_n = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      busy        <= '0;
      is_store    <= '0;
      dest        <= '{default: '0};
      rf_we_r     <= 1'b0;
      rf_waddr_r  <= '0;
      rf_wdata_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      cdb_clear_r <= '0;
    end else begin
      state       <= state_n;
      head        <= head_n;
      tail        <= tail_n;
      count       <= count_n;
      busy        <= busy_n;
      is_store    <= store_n;
      dest        <= dest_n;
      rf_we_r     <= rf_we_n;
      rf_waddr_r  <= rf_waddr_n;
      rf_wdata_r  <= rf_wdata_n;
      mem_we_r    <= mem_we_n;
      mem_addr_r  <= mem_addr_n;
      mem_wdata_r <= mem_wdata_n;
      cdb_clear_r <= cdb_clear_n;
    end
  end

  assign bus.alloc_ready  = !full && !bus.flush;
  assign bus.alloc_index  = tail;
  assign bus.cdb_clear    = cdb_clear_r;
  assign bus.rf_we        = rf_we_r;
  assign bus.rf_waddr     = rf_waddr_r;
  assign bus.rf_wdata     = rf_wdata_r;
  assign bus.mem_we       = mem_we_r && !bus.flush;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.mem_wdata    = mem_wdata_r;
  assign bus.rb_count     = count;
  assign bus.commit_state = state;

`ifdef ROB_COMMIT_STATS_EN
  logic commit_fire;
  assign commit_fire = retire && !bus.flush;

  // Survives flush on purpose; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_count <= '0;
    end else if (commit_fire && (commit_count != 32'hFFFF_FFFF)) begin
      commit_count <= commit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed scenarios with a commit scoreboard.
module tb_rob_commit_unit;
  localparam int WS = 32;
  localparam int RS = 8;
  localparam int RI = 3;
  localparam int GI = 5;
  localparam int EW = 73;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rob_commit_if #(.WORD_SIZE(WS), .RB_SIZE(RS), .RB_INDEX(RI), .REG_INDEX(GI)) bus();

`ifdef ROB_COMMIT_STATS_EN
  logic [31:0] commit_count;
`endif

  rob_commit_unit #(.WORD_SIZE(WS), .RB_SIZE(RS), .RB_INDEX(RI), .REG_INDEX(GI)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef ROB_COMMIT_STATS_EN
    ,
    .commit_count(commit_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Item layout: {is_store, cdb_clear, reg_or_addr, data}
  function automatic logic [EW-1:0] rf_item(input int idx, input logic [31:0] rg, input logic [31:0] data);
    logic [7:0] oh;
    oh = 8'd1 << idx;
    return {1'b0, oh, rg, data};
  endfunction

  function automatic logic [EW-1:0] st_item(input logic [31:0] addr, input logic [31:0] data);
    return {1'b1, 8'h00, addr, data};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rf_we) begin
        logic [EW-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check("rf_commit", {1'b0, bus.cdb_clear, 32'(bus.rf_waddr), bus.rf_wdata}, e);
      end
      if (bus.mem_we && bus.mem_ack) begin
        logic [EW-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check("store_commit", {1'b1, bus.cdb_clear, bus.mem_addr, bus.mem_wdata}, e);
      end
    end
  end

  // Clock/reset and driver tasks; the CDB stage drops valid bits on cdb_clear.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.cdb_valid = bus.cdb_valid & ~bus.cdb_clear;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.alloc_req = 1'b0;
    bus.alloc_store = 1'b0;
    bus.alloc_dest = '0;
    bus.cdb_valid = '0;
    bus.cdb_data = '0;
    bus.cdb_addr = '0;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic alloc(input bit st, input int dst);
    bus.alloc_req = 1'b1;
    bus.alloc_store = st;
    bus.alloc_dest = GI'(dst);
    tick();
    bus.alloc_req = 1'b0;
  endtask

  task automatic complete(input int idx, input logic [31:0] data, input logic [31:0] addr);
    bus.cdb_data[idx*WS +: WS] = data;
    bus.cdb_addr[idx*WS +: WS] = addr;
    bus.cdb_valid[idx] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d [5];
    int hi;

    do_reset();
    check("rst_count", bus.rb_count, 0);
    check("rst_alloc_ready", bus.alloc_ready, 1);
    check("rst_alloc_index", bus.alloc_index, 0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_cdb_clear", bus.cdb_clear, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);

    // Out-of-order completion, in-order commit
    for (int i = 0; i < 3; i++) begin
      check("ooo_alloc_index", bus.alloc_index, i);
      alloc(1'b0, i + 1);
    end
    check("ooo_count", bus.rb_count, 3);
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      exp_q.push_back(rf_item(i, i + 1, d[i]));
    end
    complete(2, d[2], 0);
    tick();
    check("ooo_no_early_commit", bus.rf_we, 0);
    complete(0, d[0], 0);
    tick();
    complete(1, d[1], 0);
    repeat (3) tick();
    check("ooo_drained_count", bus.rb_count, 0);
    check("ooo_queue", exp_q.size(), 0);

    // Full buffer and wrap
    do_reset();
    for (int i = 0; i < 8; i++) alloc(1'b0, 8 + i);
    check("full_count", bus.rb_count, 8);
    check("full_alloc_ready", bus.alloc_ready, 0);
    bus.alloc_req = 1'b1;
    bus.alloc_dest = 5'd31;
    tick();
    check("full_9th_ignored", bus.rb_count, 8);
    check("full_tail_wrapped", bus.alloc_index, 0);
    d[0] = $urandom;
    exp_q.push_back(rf_item(0, 8, d[0]));
    complete(0, d[0], 0);
    tick();
    check("full_retire_count", bus.rb_count, 7);
    check("full_ready_after_retire", bus.alloc_ready, 1);
    check("full_grant_index", bus.alloc_index, 0);
    tick();
    bus.alloc_req = 1'b0;
    check("full_regrant_count", bus.rb_count, 8);
    check("full_tail_after_grant", bus.alloc_index, 1);
    check("full_queue", exp_q.size(), 0);

    // Store handshake followed by a ready younger ALU op
    do_reset();
    alloc(1'b1, 0);
    alloc(1'b0, 7);
    d[1] = $urandom;
    exp_q.push_back(st_item(32'h100, 32'hDEAD));
    exp_q.push_back(rf_item(1, 7, d[1]));
    complete(1, d[1], 0);
    complete(0, 32'hDEAD, 32'h100);
    hi = 0;
    tick();
    check("st_mem_addr", bus.mem_addr, 32'h100);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEAD);
    check("st_state", bus.commit_state, 1);
    repeat (3) begin
      if (bus.mem_we) hi++;
      tick();
    end
    if (bus.mem_we) hi++;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("st_mem_we_cycles", hi, 4);
    check("st_mem_we_dropped", bus.mem_we, 0);
    check("st_alu_not_early", bus.rf_we, 0);
    check("st_clear", bus.cdb_clear, 8'h01);
    check("st_count", bus.rb_count, 1);
    tick();
    check("st_alu_next_cycle", bus.rf_we, 1);
    tick();
    check("st_drained", bus.rb_count, 0);

    // Alloc and retire on one edge; stale valid on an empty slot
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1'b0, i + 1);
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    exp_q.push_back(rf_item(0, 1, d[0]));
    complete(0, d[0], 0);
    bus.alloc_req = 1'b1;
    bus.alloc_dest = 5'd20;
    tick();
    bus.alloc_req = 1'b0;
    check("sim_count", bus.rb_count, 4);
    check("sim_tail", bus.alloc_index, 5);
    complete(6, 32'hBAD0BAD0, 0);
    tick();
    tick();
    check("stale_no_commit", bus.rf_we, 0);
    check("stale_count", bus.rb_count, 4);
    bus.cdb_valid[6] = 1'b0;
    for (int i = 1; i < 5; i++) begin
      exp_q.push_back(rf_item(i, (i == 4) ? 20 : i + 1, d[i]));
      complete(i, d[i], 0);
    end
    repeat (6) tick();
    check("sim_drained", bus.rb_count, 0);
    check("sim_queue", exp_q.size(), 0);

    // Flush while a store waits for its ack
    do_reset();
    alloc(1'b1, 0);
    for (int i = 0; i < 4; i++) alloc(1'b0, i + 2);
    complete(0, 32'h55, 32'h200);
    tick();
    check("fl_mem_we_before", bus.mem_we, 1);
    check("fl_count_before", bus.rb_count, 5);
    bus.flush = 1'b1;
    bus.mem_ack = 1'b1;
    #1;
    check("fl_mem_we_now", bus.mem_we, 0);
    check("fl_alloc_ready", bus.alloc_ready, 0);
    tick();
    bus.flush = 1'b0;
    bus.mem_ack = 1'b0;
    check("fl_clear_all", bus.cdb_clear, 8'hFF);
    check("fl_count", bus.rb_count, 0);
    check("fl_mem_we", bus.mem_we, 0);
    check("fl_rf_we", bus.rf_we, 0);
    check("fl_state", bus.commit_state, 0);
    check("fl_alloc_index", bus.alloc_index, 0);
    tick();
    check("fl_clear_one_cycle", bus.cdb_clear, 0);
    d[0] = $urandom;
    alloc(1'b0, 9);
    exp_q.push_back(rf_item(0, 9, d[0]));
    complete(0, d[0], 0);
    repeat (3) tick();
    check("fl_queue", exp_q.size(), 0);

`ifdef ROB_COMMIT_STATS_EN
    do_reset();
    check("stats_reset", commit_count, 0);
    for (int k = 0; k < 10; k++) begin
      d[0] = $urandom;
      exp_q.push_back(rf_item(k % 8, k, d[0]));
      alloc(1'b0, k);
      complete(k % 8, d[0], 0);
      tick();
      tick();
    end
    check("stats_ten", commit_count, 10);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    check("stats_after_flush", commit_count, 10);
    reset = 1'b1;
    #1;
    check("stats_cleared", commit_count, 0);
    reset = 1'b0;
    tick();
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
